// File: rtl/interleaver_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// interleaver_addr_gen_pkg
// Shared definitions for the block interleaver address generator:
//   state_t      - FSM state encoding (IDLE / WRITE / READ)
//   ROWS_DEF     - default number of matrix rows
//   COLS_DEF     - default number of matrix columns
//   ROW_W        - row_sel width (feeds a 4-to-16 row decoder directly)
//   col_width()  - column address width, max(1, ceil(log2(cols)))
// ---------------------------------------------------------------------------
package interleaver_addr_gen_pkg;

   localparam int ROWS_DEF = 12;
   localparam int COLS_DEF = 8;
   localparam int ROW_W    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   // $clog2(2) is already 1; the guard only protects COLS=1 style builds.
   function automatic int col_width(input int cols);
      return (cols > 2) ? $clog2(cols) : 1;
   endfunction

endpackage

// File: rtl/interleaver_addr_gen_rc_counter.sv
// ---------------------------------------------------------------------------
// interleaver_rc_counter
// Row/column address counter shared by the write (row-wise fill) and the
// read (column-wise drain) phase of the interleaver.
//
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset, forces row=0, col=0
//   clear          - synchronous return to (0,0) ("no row")
//   load           - synchronous load of the first address (1,0)
//   step           - advance by one symbol
//   inc_major_row  - 0: column runs fastest (fill), 1: row runs fastest (drain)
//   row            - row index 1..ROWS, 0 = no row
//   col            - column index 0..COLS-1
//   last           - current address is (ROWS, COLS-1)
//
// Priority: clear > load > step.
// ---------------------------------------------------------------------------
module interleaver_rc_counter
   import interleaver_addr_gen_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   parameter int CW   = col_width(COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic             inc_major_row,
   output logic [ROW_W-1:0] row,
   output logic [CW-1:0]    col,
   output logic             last
);

   localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(1);
   localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(ROWS);
   localparam logic [CW-1:0]    COL_MAX   = CW'(COLS - 1);

   logic row_at_max;
   logic col_at_max;

   assign row_at_max = (row == ROW_MAX);
   assign col_at_max = (col == COL_MAX);
   assign last       = row_at_max && col_at_max;

   // The wrap out of the final address is never used: the controller
   // issues load or clear instead of step at (ROWS, COLS-1).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (load) begin
         row <= ROW_FIRST;
         col <= '0;
      end else if (step) begin
         if (inc_major_row) begin
            if (row_at_max) begin
               row <= ROW_FIRST;
               col <= col + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            if (col_at_max) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/interleaver_addr_gen.sv
// ---------------------------------------------------------------------------
// interleaver_addr_gen
// Address and strobe generator for a ROWS x COLS block interleaver.  A frame
// writes ROWS*COLS symbols row by row, then reads them back column by column.
// The block holds no symbol storage; it only drives the memory addresses.
//
// Parameters:
//   ROWS  - matrix rows (2..15)
//   COLS  - matrix columns (2..16)
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset, discards any partial frame
//   start      - begins a frame when sampled high in IDLE
//   in_valid   - upstream symbol available
//   in_ready   - block accepts a write symbol (WRITE phase)
//   out_ready  - downstream accepts a read symbol
//   out_valid  - read address presented (READ phase)
//   row_sel    - row index 1..ROWS, 0 = no row (drives the row decoder)
//   col_addr   - column index 0..COLS-1
//   wr_en      - write strobe, in_valid & in_ready
//   rd_en      - read strobe, out_valid & out_ready
//   busy       - state is not IDLE
//   frame_done - one-cycle pulse in the cycle after the last read
// ---------------------------------------------------------------------------
module interleaver_addr_gen
   import interleaver_addr_gen_pkg::*;
#(
   parameter int ROWS = ROWS_DEF,
   parameter int COLS = COLS_DEF,
   localparam int CW  = col_width(COLS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [ROW_W-1:0] row_sel,
   output logic [CW-1:0]    col_addr,
   output logic             wr_en,
   output logic             rd_en,
   output logic             busy,
   output logic             frame_done
);

   state_t state;
   state_t state_nxt;

   logic   cnt_clear;
   logic   cnt_load;
   logic   cnt_step;
   logic   cnt_major_row;
   logic   cnt_last;

   // -----------------------------------------------------------------------
   // Shared address counter
   // -----------------------------------------------------------------------
   interleaver_rc_counter #(
      .ROWS (ROWS),
      .COLS (COLS),
      .CW   (CW)
   ) u_rc_counter (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (cnt_clear),
      .load          (cnt_load),
      .step          (cnt_step),
      .inc_major_row (cnt_major_row),
      .row           (row_sel),
      .col           (col_addr),
      .last          (cnt_last)
   );

   // -----------------------------------------------------------------------
   // FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      cnt_clear     = 1'b0;
      cnt_load      = 1'b0;
      cnt_step      = 1'b0;
      cnt_major_row = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               cnt_load  = 1'b1;
               state_nxt = WRITE;
            end else begin
               cnt_clear = 1'b1;
            end
         end

         WRITE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (cnt_last) begin
                  // Final write: re-arm the counter at (1,0) for the drain.
                  cnt_load  = 1'b1;
                  state_nxt = READ;
               end else begin
                  cnt_step = 1'b1;
               end
            end
         end

         READ: begin
            out_valid     = 1'b1;
            cnt_major_row = 1'b1;
            if (out_ready) begin
               if (cnt_last) begin
                  cnt_clear = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  cnt_step = 1'b1;
               end
            end
         end

         default: begin
            cnt_clear = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   // -----------------------------------------------------------------------
   // Strobes and status
   // -----------------------------------------------------------------------
   assign wr_en = in_valid & in_ready;
   assign rd_en = out_valid & out_ready;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= rd_en && cnt_last;
      end
   end

endmodule

// File: tb/tb_interleaver_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_interleaver_addr_gen
// Scoreboard bench: the expected write and read address orders of a frame are
// queued when the frame is started and popped on every wr_en / rd_en.  A
// second 2x2 instance exercises the smallest legal matrix.
// ---------------------------------------------------------------------------
module tb_interleaver_addr_gen;
   import interleaver_addr_gen_pkg::*;

   localparam int R  = 12;
   localparam int C  = 8;
   localparam int R2 = 2;
   localparam int C2 = 2;

   typedef struct {
      int row;
      int col;
   } addr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic             out_ready;
   logic             out_valid;
   logic [ROW_W-1:0] row_sel;
   logic [2:0]       col_addr;
   logic             wr_en;
   logic             rd_en;
   logic             busy;
   logic             frame_done;

   logic             s_start;
   logic             s_in_valid;
   logic             s_in_ready;
   logic             s_out_ready;
   logic             s_out_valid;
   logic [ROW_W-1:0] s_row_sel;
   logic [0:0]       s_col_addr;
   logic             s_wr_en;
   logic             s_rd_en;
   logic             s_busy;
   logic             s_frame_done;

   interleaver_addr_gen #(.ROWS(R), .COLS(C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .row_sel    (row_sel),
      .col_addr   (col_addr),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .busy       (busy),
      .frame_done (frame_done)
   );

   interleaver_addr_gen #(.ROWS(R2), .COLS(C2)) dut_2x2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (s_start),
      .in_valid   (s_in_valid),
      .in_ready   (s_in_ready),
      .out_ready  (s_out_ready),
      .out_valid  (s_out_valid),
      .row_sel    (s_row_sel),
      .col_addr   (s_col_addr),
      .wr_en      (s_wr_en),
      .rd_en      (s_rd_en),
      .busy       (s_busy),
      .frame_done (s_frame_done)
   );

   addr_t wq[$];
   addr_t rq[$];
   addr_t q2[$];
   int    vectors     = 0;
   int    miscompares = 0;
   int    ph          = 0;   // model phase: 0 idle, 1 write, 2 read

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Runs one frame on the 12x8 instance from a negedge in IDLE.
   //   stall : randomise in_valid / out_ready
   //   poke  : pulse start while writing row 5
   //   abort : assert reset while (7,3) is presented in READ
   task automatic run_frame(input bit stall, input bit poke, input bit abort);
      int    wcnt  = 0;
      int    rcnt  = 0;
      int    cyc   = 0;
      bit    poked = 0;
      bit    done  = 0;
      addr_t a;

      for (int r = 1; r <= R; r++)
         for (int c = 0; c < C; c++)
            wq.push_back('{row: r, col: c});
      for (int c = 0; c < C; c++)
         for (int r = 1; r <= R; r++)
            rq.push_back('{row: r, col: c});

      start     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("idle_in_ready", in_ready, 0);
      check("idle_row", row_sel, 0);
      @(negedge clk);
      start = 1'b0;
      ph    = 1;

      while (!done && cyc < 5000) begin
         cyc++;
         in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = 1'b0;
         if (poke && !poked && ph == 1 && wq.size() > 0 && wq[0].row == 5) begin
            start = 1'b1;
            poked = 1;
         end

         if (abort && ph == 2 && rq.size() > 0 && rq[0].row == 7 && rq[0].col == 3) begin
            #1;
            check("abort_pre_row", row_sel, 7);
            check("abort_pre_col", col_addr, 3);
            rst_n = 1'b0;
            #1;
            check("abort_row", row_sel, 0);
            check("abort_col", col_addr, 0);
            check("abort_busy", busy, 0);
            check("abort_out_valid", out_valid, 0);
            repeat (2) begin
               @(negedge clk);
               #1;
               check("abort_frame_done", frame_done, 0);
            end
            rst_n     = 1'b1;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            repeat (3) begin
               @(negedge clk);
               #1;
               check("post_rst_busy", busy, 0);
               check("post_rst_in_ready", in_ready, 0);
               check("post_rst_wr_en", wr_en, 0);
               check("post_rst_frame_done", frame_done, 0);
               check("post_rst_row", row_sel, 0);
            end
            wq.delete();
            rq.delete();
            ph = 0;
            @(negedge clk);
            return;
         end

         #1;
         check("in_ready", in_ready, (ph == 1));
         check("out_valid", out_valid, (ph == 2));
         check("busy", busy, (ph != 0));
         check("frame_done_low", frame_done, 0);
         if (wr_en) begin
            if (wq.size() == 0) begin
               check("wr_extra", 1, 0);
            end else begin
               a = wq.pop_front();
               check("wr_row", row_sel, a.row);
               check("wr_col", col_addr, a.col);
               wcnt++;
               if (wq.size() == 0) ph = 2;
            end
         end
         if (rd_en) begin
            if (rq.size() == 0) begin
               check("rd_extra", 1, 0);
            end else begin
               a = rq.pop_front();
               check("rd_row", row_sel, a.row);
               check("rd_col", col_addr, a.col);
               rcnt++;
               if (rq.size() == 0) begin
                  ph   = 0;
                  done = 1;
               end
            end
         end
         @(negedge clk);
      end

      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("frame_timeout", done, 1);
      #1;
      check("frame_done_pulse", frame_done, done);
      check("done_busy", busy, 0);
      check("done_row", row_sel, 0);
      check("wr_count", wcnt, R * C);
      check("rd_count", rcnt, R * C);
      @(negedge clk);
      #1;
      check("frame_done_single", frame_done, 0);
      wq.delete();
      rq.delete();
      @(negedge clk);
   endtask

   task automatic run_2x2();
      int    w2r[4] = '{1, 1, 2, 2};
      int    w2c[4] = '{0, 1, 0, 1};
      int    r2r[4] = '{1, 2, 1, 2};
      int    r2c[4] = '{0, 0, 1, 1};
      int    cyc    = 0;
      addr_t a;

      for (int i = 0; i < 4; i++) q2.push_back('{row: w2r[i], col: w2c[i]});
      for (int i = 0; i < 4; i++) q2.push_back('{row: r2r[i], col: r2c[i]});

      s_start = 1'b1;
      @(negedge clk);
      s_start     = 1'b0;
      s_in_valid  = 1'b1;
      s_out_ready = 1'b1;
      while (q2.size() > 0 && cyc < 40) begin
         cyc++;
         #1;
         if (s_wr_en || s_rd_en) begin
            a = q2.pop_front();
            check("s_row", s_row_sel, a.row);
            check("s_col", s_col_addr, a.col);
            check("s_phase", s_rd_en, (q2.size() < 4));
         end
         @(negedge clk);
      end
      check("s_timeout", q2.size(), 0);
      #1;
      check("s_frame_done", s_frame_done, 1);
      check("s_busy", s_busy, 0);
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;
      q2.delete();
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      s_start     = 1'b0;
      s_in_valid  = 1'b0;
      s_out_ready = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      check("rst_row", row_sel, 0);
      check("rst_col", col_addr, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_s_row", s_row_sel, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_frame(0, 0, 0);   // continuous flow
      run_frame(1, 0, 0);   // random stalls
      run_frame(0, 1, 0);   // start pulsed mid-WRITE
      run_frame(1, 1, 0);
      run_frame(0, 0, 1);   // reset during READ at (7,3)
      run_frame(0, 0, 0);   // fresh frame after the abort
      run_2x2();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/interleaver_addr_gen.md
INTERLEAVER_ADDR_GEN -- requirements
Module: interleaver_addr_gen

Interface
REQ-001 The block SHALL have parameter ROWS, default 12, meaning rows of the interleaver matrix (legal range 2..15).
REQ-002 The block SHALL have parameter COLS, default 8, meaning columns of the interleaver matrix (legal range 2..16).
REQ-003 The block SHALL have localparam CW = max(1, ceil(log2(COLS))), meaning the column address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a frame when sampled high in IDLE.
REQ-007 The block SHALL have port in_valid, input, 1 bit: upstream symbol available.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a write symbol.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts a read symbol.
REQ-010 The block SHALL have port out_valid, output, 1 bit: a read address is presented.
REQ-011 The block SHALL have port row_sel, output, 4 bits: row index 1..ROWS, and 0 = no row; this drives the 4-to-16 row decoder directly.
REQ-012 The block SHALL have port col_addr, output, CW bits: column index 0..COLS-1.
REQ-013 The block SHALL have port wr_en, output, 1 bit: write strobe, equal to in_valid & in_ready.
REQ-014 The block SHALL have port rd_en, output, 1 bit: read strobe, equal to out_valid & out_ready.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-016 The block SHALL have port frame_done, output, 1 bit: registered one-cycle pulse after the last read.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WRITE and READ.
REQ-018 In IDLE, the block SHALL hold row_sel=0, col_addr=0, in_ready=0 and out_valid=0.
REQ-019 start=1 in IDLE SHALL load row_sel=1 and col_addr=0 and move to WRITE on the next edge; start SHALL be ignored in any other state.
REQ-020 In WRITE, in_ready SHALL be 1 and out_valid SHALL be 0; wr_en SHALL be combinational from in_valid.
REQ-021 In WRITE, each accepted symbol SHALL advance col_addr by 1; when col_addr=COLS-1, col_addr SHALL wrap to 0 and row_sel SHALL increment (row-wise fill).
REQ-022 An accept at row_sel=ROWS, col_addr=COLS-1 SHALL load row_sel=1, col_addr=0 and enter READ on the next edge.
REQ-023 In READ, out_valid SHALL be 1 and in_ready SHALL be 0; rd_en SHALL be combinational from out_ready.
REQ-024 In READ, each accepted symbol SHALL increment row_sel; when row_sel=ROWS, row_sel SHALL wrap to 1 and col_addr SHALL increment (column-wise drain).
REQ-025 An accept at row_sel=ROWS, col_addr=COLS-1 SHALL return the FSM to IDLE and assert frame_done for exactly the following cycle.
REQ-026 Stalls (in_valid=0 in WRITE, or out_ready=0 in READ) SHALL hold row_sel and col_addr unchanged, with no limit on stall length.
REQ-027 A frame SHALL comprise exactly ROWS*COLS writes followed by exactly ROWS*COLS reads; each (row, col) pair SHALL appear once per phase.
REQ-028 row_sel and col_addr SHALL be registered; the latency from start to the first write accept SHALL be 1 cycle.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, row_sel=0, col_addr=0 and frame_done=0, including mid-WRITE or mid-READ.
REQ-030 A partial frame interrupted by reset SHALL be discarded, with no frame_done pulse.
REQ-031 After reset deasserts, the block SHALL require a new start before any further writes or reads.

Structure
REQ-032 The shared interleaver package SHALL hold the state enum (IDLE/WRITE/READ), ROWS_DEF=12, COLS_DEF=8 and the row_sel width of 4.
REQ-033 The block SHALL instantiate one sub-module, interleaver_rc_counter: a parameterised row/column counter with an inc_major_row mode select, shared by both phases.
REQ-034 The block SHALL NOT contain any memory; it SHALL generate addresses and strobes only.

Verification
REQ-035 Reset, then start, then 96 continuous in_valid cycles: the sequence SHALL be row_sel 1,1..1 (col 0..7), 2..., 12/col 7, then READ.
REQ-036 READ with out_ready=1 throughout: the sequence SHALL be (1,0),(2,0)..(12,0),(1,1)..(12,7), with frame_done=1 exactly one cycle after the 96th rd_en, then IDLE.
REQ-037 Random in_valid/out_ready stalls (~50%): the wr_en and rd_en counts SHALL each be 96, with addresses identical to the stall-free run.
REQ-038 start pulsed during WRITE at row_sel=5: there SHALL be no effect on the counters or the state.
REQ-039 rst_n low during READ at (7,3): row_sel SHALL be 0, busy SHALL be 0 and there SHALL be no frame_done; a following start SHALL restart at (1,0) in WRITE.
REQ-040 ROWS=2, COLS=2 build: the write order SHALL be (1,0),(1,1),(2,0),(2,1) and the read order SHALL be (1,0),(2,0),(1,1),(2,1).
